// File: rtl/apb_i2c_regif_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_i2c_regif_fifo_if
// Description : APB bus bundle between the fabric and the I2C register front
//               end. The master modport drives the request side. The slave
//               modport returns PRDATA, PREADY and PSLVERR.
// Ports       : PSELx, PENABLE, PWRITE, PADDR, PWDATA (master -> slave)
//               PRDATA, PREADY, PSLVERR            (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_i2c_regif_fifo_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              PSELx;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface
`default_nettype wire

// File: rtl/apb_i2c_regif_fifo.sv
`default_nettype none
// ============================================================================
// Module      : apb_i2c_regif_fifo
// Description : APB slave front end for the I2C core. It contains the TX and
//               RX FIFOs, the CONFIG and TIMEOUT registers, and a sticky,
//               maskable interrupt block that drives a single registered IRQ.
//               All accesses complete with zero wait states.
// Ports       : PCLK, PRESETn        - clock, async active-low reset
//               apb (slave modport)  - APB bus
//               TX_DATA/VALID/READY  - TX FIFO head to the core
//               RX_DATA/VALID        - core pushes into the RX FIFO
//               CORE_ERROR           - core error level (rising edge latched)
//               CFG_OUT, TIMEOUT_OUT - configuration registers
//               IRQ                  - |(INT_STAT & INT_EN), registered
// Revision    : 1.0 - initial release
// ============================================================================
module apb_i2c_regif_fifo #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CFG_W      = 14
) (
  input  wire                PCLK,
  input  wire                PRESETn,
  apb_i2c_regif_fifo_if.slave apb,
  output logic [DATA_W-1:0]  TX_DATA,
  output logic               TX_VALID,
  input  wire                TX_READY,
  input  wire  [DATA_W-1:0]  RX_DATA,
  input  wire                RX_VALID,
  input  wire                CORE_ERROR,
  output logic [CFG_W-1:0]   CFG_OUT,
  output logic [CFG_W-1:0]   TIMEOUT_OUT,
  output logic               IRQ
);
  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [ADDR_W-1:0] c_A_TX   = ADDR_W'('h00);
  localparam logic [ADDR_W-1:0] c_A_RX   = ADDR_W'('h04);
  localparam logic [ADDR_W-1:0] c_A_TMO  = ADDR_W'('h08);
  localparam logic [ADDR_W-1:0] c_A_CFG  = ADDR_W'('h0C);
  localparam logic [ADDR_W-1:0] c_A_STAT = ADDR_W'('h10);
  localparam logic [ADDR_W-1:0] c_A_IEN  = ADDR_W'('h14);
  localparam logic [ADDR_W-1:0] c_A_IST  = ADDR_W'('h18);
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(FIFO_DEPTH);

  // FIFO storage and pointers
  logic [DATA_W-1:0]  r_tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0]  r_rx_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic [c_CNT_W-1:0] r_tx_cnt, r_rx_cnt;

  // Registers
  logic [CFG_W-1:0] r_cfg, r_tmo;
  logic [3:0]       r_int_en, r_int_stat;
  logic             r_irq, r_cerr_d;

  logic               w_acc, w_err;
  logic [DATA_W-1:0]  w_rd;
  logic               w_tx_push, w_tx_pop, w_tx_empty, w_tx_full;
  logic               w_rx_push, w_rx_pop, w_rx_empty, w_rx_full, w_rx_ovf;
  logic               w_cfg_we, w_tmo_we, w_ien_we;
  logic [3:0]         w_clr, w_set;
  logic [c_CNT_W-1:0] w_tx_cnt_nxt, w_rx_cnt_nxt;
  logic [31:0]        w_status;

  assign w_acc      = apb.PSELx & apb.PENABLE;
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == c_FULL);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == c_FULL);
  assign w_status   = {8'd0, 8'(r_rx_cnt), 8'(r_tx_cnt), 4'd0,
                       w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};

  // Address decode. Any rejected access has no side effect and returns zero.
  always_comb begin
    w_err     = 1'b0;
    w_rd      = '0;
    w_tx_push = 1'b0;
    w_rx_pop  = 1'b0;
    w_cfg_we  = 1'b0;
    w_tmo_we  = 1'b0;
    w_ien_we  = 1'b0;
    w_clr     = '0;
    if (w_acc) begin
      case (apb.PADDR)
        c_A_TX:   if (!apb.PWRITE || w_tx_full) w_err = 1'b1;
                  else w_tx_push = 1'b1;
        c_A_RX:   if (apb.PWRITE || w_rx_empty) w_err = 1'b1;
                  else begin
                    w_rx_pop = 1'b1;
                    w_rd     = r_rx_mem[r_rx_rp];
                  end
        c_A_TMO:  if (apb.PWRITE) w_tmo_we = 1'b1;
                  else w_rd = DATA_W'(r_tmo);
        c_A_CFG:  if (apb.PWRITE) w_cfg_we = 1'b1;
                  else w_rd = DATA_W'(r_cfg);
        c_A_STAT: if (apb.PWRITE) w_err = 1'b1;
                  else w_rd = DATA_W'(w_status);
        c_A_IEN:  if (apb.PWRITE) w_ien_we = 1'b1;
                  else w_rd = DATA_W'(r_int_en);
        c_A_IST:  if (apb.PWRITE) w_clr = apb.PWDATA[3:0];
                  else w_rd = DATA_W'(r_int_stat);
        default:  w_err = 1'b1;
      endcase
    end
  end

  assign apb.PREADY  = w_acc;
  assign apb.PSLVERR = w_err;
  assign apb.PRDATA  = w_rd;

  // TX FIFO: fullness was already checked before any same-cycle pop.
  assign TX_VALID     = ~w_tx_empty;
  assign TX_DATA      = r_tx_mem[r_tx_rp];
  assign w_tx_pop     = TX_VALID & TX_READY;
  assign w_tx_cnt_nxt = r_tx_cnt + c_CNT_W'(w_tx_push) - c_CNT_W'(w_tx_pop);

  // RX FIFO: an APB pop in the same cycle makes room for the core push.
  assign w_rx_ovf     = RX_VALID & w_rx_full & ~w_rx_pop;
  assign w_rx_push    = RX_VALID & ~w_rx_ovf;
  assign w_rx_cnt_nxt = r_rx_cnt + c_CNT_W'(w_rx_push) - c_CNT_W'(w_rx_pop);

  assign w_set[0] = (r_tx_cnt == c_CNT_W'(1)) & (w_tx_cnt_nxt == '0);
  assign w_set[1] = (r_rx_cnt == '0) & (w_rx_cnt_nxt != '0);
  assign w_set[2] = w_rx_ovf;
  assign w_set[3] = CORE_ERROR & ~r_cerr_d;

  // Storage is not reset. Reset empties the FIFOs through the pointers.
  always_ff @(posedge PCLK) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= apb.PWDATA;
    if (w_rx_push) r_rx_mem[r_rx_wp] <= RX_DATA;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_tx_wp    <= '0;
      r_tx_rp    <= '0;
      r_tx_cnt   <= '0;
      r_rx_wp    <= '0;
      r_rx_rp    <= '0;
      r_rx_cnt   <= '0;
      r_cfg      <= '0;
      r_tmo      <= '0;
      r_int_en   <= '0;
      r_int_stat <= '0;
      r_irq      <= 1'b0;
      r_cerr_d   <= 1'b0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + c_PTR_W'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + c_PTR_W'(1);
      if (w_rx_push) r_rx_wp <= r_rx_wp + c_PTR_W'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + c_PTR_W'(1);
      r_tx_cnt <= w_tx_cnt_nxt;
      r_rx_cnt <= w_rx_cnt_nxt;
      if (w_cfg_we) r_cfg    <= apb.PWDATA[CFG_W-1:0];
      if (w_tmo_we) r_tmo    <= apb.PWDATA[CFG_W-1:0];
      if (w_ien_we) r_int_en <= apb.PWDATA[3:0];
      // A set and a clear on the same bit in the same cycle leave it set.
      r_int_stat <= (r_int_stat & ~w_clr) | w_set;
      r_irq      <= |(r_int_stat & r_int_en);
      r_cerr_d   <= CORE_ERROR;
    end
  end

  assign CFG_OUT     = r_cfg;
  assign TIMEOUT_OUT = r_tmo;
  assign IRQ         = r_irq;
endmodule
`default_nettype wire

// File: doc/apb_i2c_regif_fifo.md
Name: apb_i2c_regif_fifo

Overview:
Parametrised APB slave front-end for the I2C core, replacing the pass-through register interface. It has internal TX and RX FIFOs and range-checked configuration and timeout registers. It also provides a maskable sticky interrupt block with a single IRQ line, and reports PSLVERR for protocol and access errors. It sits between the APB fabric and the I2C core (byte/word engine).

Parameters:
DATA_W, 32, APB data width and FIFO entry width (8..32)
ADDR_W, 32, APB address width
FIFO_DEPTH, 8, entries per FIFO; power of two, 2..128
CFG_W, 14, width of CONFIG and TIMEOUT registers (<= DATA_W)

Ports:
PCLK  in  1  clock
PRESETn  in  1  reset; asynchronous assert, active-low
PSELx  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  1=write, 0=read
PADDR  in  ADDR_W  byte address
PWDATA  in  DATA_W  write data
PRDATA  out  DATA_W  read data
PREADY  out  1  transfer complete
PSLVERR  out  1  transfer error, valid when PREADY=1
TX_DATA  out  DATA_W  TX FIFO head to core
TX_VALID  out  1  TX FIFO not empty
TX_READY  in  1  core pops TX head when TX_VALID & TX_READY
RX_DATA  in  DATA_W  data from core
RX_VALID  in  1  core pushes RX_DATA (no backpressure)
CORE_ERROR  in  1  I2C core error level
CFG_OUT  out  CFG_W  CONFIG register
TIMEOUT_OUT  out  CFG_W  TIMEOUT register
IRQ  out  1  |(INT_STAT & INT_EN), registered

Behaviour:
- Reset (PRESETn low, async): both FIFOs empty; CONFIG, TIMEOUT, INT_EN, INT_STAT = 0; IRQ=0; TX_VALID=0; PRDATA=0; PSLVERR=0.
- Access cycle: acc = PSELx & PENABLE. PREADY = acc (zero wait states). PRDATA is 0 outside read accesses.
- Register map (offsets; any other PADDR -> PSLVERR=1, no side effect, PRDATA=0):
  - 0x00 TXDATA (W): push PWDATA.
  - 0x04 RXDATA (R): PRDATA=head; pop at access cycle.
  - 0x08 TIMEOUT (RW).
  - 0x0C CONFIG (RW). Write takes PWDATA[CFG_W-1:0]; read zero-extends.
  - 0x10 STATUS (R): [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [15:8] tx_count, [23:16] rx_count.
  - 0x14 INT_EN (RW, bits [3:0]).
  - 0x18 INT_STAT (R, W1C, bits [3:0]).
- Access errors (PSLVERR=1, access ignored):
  - Write to a read-only offset, or read of TXDATA.
  - TXDATA write while tx_full. Full is evaluated before any same-cycle core pop, so the write is rejected even if a pop occurs.
  - RXDATA read while rx_empty (PRDATA=0).
- Register update: registers update on the PCLK edge ending the access cycle. FIFO push and pop in the same cycle leave count unchanged and preserve order.
- Read pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH+1).
- TX pop: a pop occurs when TX_VALID & TX_READY. TX_DATA is stable while TX_VALID & !TX_READY.
- RX push: a push occurs when RX_VALID. If rx_full, the data is dropped and INT_STAT[2] is set. If an APB pop and a core push hit a full FIFO in the same cycle, both are accepted and there is no overflow.
- INT_STAT set sources (sticky):
  - [0] tx_count goes 1->0.
  - [1] rx_count goes 0->nonzero.
  - [2] RX overflow.
  - [3] CORE_ERROR rising edge, registered.
- INT_STAT clear: W1C. If a set and a clear hit the same bit in the same cycle, set wins.
- IRQ latency: IRQ updates one cycle after INT_STAT or INT_EN changes.
- Reset mid-transfer: async reset discards FIFO contents and pending interrupts immediately; the outputs take reset values without waiting for a clock edge.

Test Plan:
1. Write 0x0C=0xFFFF_3ABC, read 0x0C -> CFG_OUT=0x3ABC, PRDATA=0x0000_3ABC, PSLVERR=0.
2. Hold TX_READY=0, write TXDATA FIFO_DEPTH+1 times (values 1..9) -> writes 1-8 accepted, 9th returns PSLVERR=1, STATUS[1]=1, tx_count=8. Then assert TX_READY -> TX_DATA sequence 1..8, INT_STAT[0]=1 after the last pop.
3. Read RXDATA when empty -> PSLVERR=1, PRDATA=0. Push 0xA5 via RX_VALID -> INT_STAT[1]=1; with INT_EN=0x2, IRQ=1 one cycle later. Read RXDATA -> 0xA5.
4. Push 9 words with no reads -> 9th dropped, INT_STAT[2]=1, rx_count=8. Write INT_STAT=0x4 -> bit 2 clears; a same-cycle overflow instead keeps bit 2 set.
5. Access PADDR=0x20, and write PADDR=0x10 -> PSLVERR=1, no register changes.
6. Fill both FIFOs, set CONFIG=0x1, pulse PRESETn low mid-cycle -> all outputs return to reset values immediately and STATUS reads 0x0000_0005.
